seq_fsm_core: RTL
=================

SEQ_FSM_CORE -- requirements
Module: seq_fsm_core

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of z_count (valid 2..16).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port x  input  1  FSM data input, sampled only when x_valid=1.
REQ-005 SHALL have port x_valid  input  1  step enable; FSM advances one transition per clk with x_valid=1.
REQ-006 SHALL have port load  input  1  force-state request.
REQ-007 SHALL have port load_state  input  3  state value for load.
REQ-008 SHALL have port count_clr  input  1  synchronous clear of z_count.
REQ-009 SHALL have port y  output  3  registered current state.
REQ-010 SHALL have port z  output  1  Moore output, decoded from registered y only.
REQ-011 SHALL have port z_count  output  CNT_W  saturating count of accepted steps taken while z=1.
REQ-012 SHALL have port load_err  output  1  registered one-cycle pulse on rejected load.

Function
REQ-013 SHALL implement five legal states, encoded 000, 001, 010, 011, 100.
REQ-014 SHALL use these transitions on an accepted step (x=0 / x=1): 000->000/001; 001->001/100; 010->010/001; 011->001/010; 100->011/100.
REQ-015 SHALL drive z=1 in states 011 and 100, and z=0 in 000, 001, 010.
REQ-016 SHALL hold y unchanged on any cycle with x_valid=0 and load=0; x is don't-care then.
REQ-017 SHALL give the next state one cycle after the accepted edge: y updates at the same rising edge that samples x; z follows combinationally from the new y.
REQ-018 SHALL give load priority over x_valid: with load=1 and load_state<=100, y<=load_state and no step is taken that cycle.
REQ-019 SHALL reject load when load_state is 101..111: y holds, no step is taken even if x_valid=1, and load_err=1 on the next cycle only.
REQ-020 SHALL recover any state 101..111 found in y (e.g. an upset) to 000 on the next clock edge, regardless of x_valid or load.
REQ-021 SHALL increment z_count by 1 on each accepted step (x_valid=1, load=0) whose pre-step state has z=1.
REQ-022 SHALL saturate z_count at 2^CNT_W-1; it SHALL NOT wrap.
REQ-023 SHALL make count_clr=1 set z_count to 0 at the next edge, overriding a same-cycle increment.
REQ-024 SHALL leave z_count unaffected by load and by illegal-state recovery.
REQ-025 SHALL have no combinational path from x, x_valid, load or load_state to any output.

Reset
REQ-026 SHALL, while resetn=0, immediately force y=000, z=0, z_count=0, load_err=0, independent of clk.
REQ-027 SHALL take no step and no load on the first rising edge coinciding with resetn deassertion; normal operation starts at the following edge.
REQ-028 SHALL abandon an in-progress sequence when reset asserts mid-operation; no state is retained.

Verification
REQ-029 SHALL cover: reset, then x_valid=1 with x=1,1,0,0,1 on consecutive edges -> y=001,100,011,001,100; z=0,1,1,0,1; z_count=2.
REQ-030 SHALL cover: y=010, x_valid=0 for 10 cycles with x toggling -> y stays 010, z_count unchanged.
REQ-031 SHALL cover: load=1, load_state=110, x_valid=1 -> y holds; load_err high for exactly 1 cycle; next cycle load_state=011 loads y=011, z=1.
REQ-032 SHALL cover: CNT_W=2, hold y=100 with x=1 stepping 6 times -> z_count saturates at 3; count_clr and a step in the same cycle -> z_count=0.
REQ-033 SHALL cover: resetn pulsed low between edges while y=100 and z_count=5 -> y=000, z=0, z_count=0 before the next edge.
REQ-034 SHALL cover: exhaustive sweep of all 5 states x 2 inputs, checked against the REQ-014 table; all 8 load_state values checked against REQ-018/019.

Source files
------------

// File: rtl/seq_fsm_core.sv
`default_nettype none
// ============================================================================
//  Module   : seq_fsm_core
//  Purpose  : Five-state Moore sequence FSM with a force-load port, illegal
//             state recovery and a saturating counter of steps taken while
//             the Moore output is high.
//  Ports    : clk         - rising-edge clock
//             resetn      - asynchronous active-low reset
//             x           - FSM data input (used only when x_valid=1)
//             x_valid     - step enable
//             load        - force-state request (priority over x_valid)
//             load_state  - state value to load (000..100 legal)
//             count_clr   - synchronous clear of z_count
//             y           - registered current state
//             z           - Moore output decoded from y
//             z_count     - saturating count of accepted steps with z=1
//             load_err    - one-cycle pulse after a rejected load
//  Revision : 1.0 - initial release
// ============================================================================
module seq_fsm_core #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             x,
  input  logic             x_valid,
  input  logic             load,
  input  logic [2:0]       load_state,
  input  logic             count_clr,
  output logic [2:0]       y,
  output logic             z,
  output logic [CNT_W-1:0] z_count,
  output logic             load_err
);

  localparam logic [2:0] S0 = 3'b000;
  localparam logic [2:0] S1 = 3'b001;
  localparam logic [2:0] S2 = 3'b010;
  localparam logic [2:0] S3 = 3'b011;
  localparam logic [2:0] S4 = 3'b100;

  logic [2:0]       y_q,   y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  // Cleared by reset; the first edge after reset release only sets it, so
  // that edge neither steps nor loads.
  logic             run_q;

  logic w_z;
  logic w_load_ok;
  logic w_illegal;
  logic w_step;

  assign w_z       = (y_q == S3) || (y_q == S4);
  assign w_load_ok = (load_state <= S4);
  assign w_illegal = (y_q > S4);
  assign w_step    = run_q && x_valid && !load;

  always_comb begin
    y_d   = y_q;
    cnt_d = cnt_q;
    err_d = 1'b0;

    if (run_q) begin
      err_d = load && !w_load_ok;

      if (w_illegal) begin
        // Recovery wins over both load and step.
        y_d = S0;
      end else if (load) begin
        if (w_load_ok) begin
          y_d = load_state;
        end
      end else if (x_valid) begin
        case (y_q)
          S0:      y_d = x ? S1 : S0;
          S1:      y_d = x ? S4 : S1;
          S2:      y_d = x ? S1 : S2;
          S3:      y_d = x ? S2 : S1;
          S4:      y_d = x ? S4 : S3;
          default: y_d = S0;
        endcase
      end
    end

    // Count uses the pre-step state's z; an illegal state decodes z=0 so
    // recovery never counts.
    if (w_step && w_z && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (count_clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      y_q   <= S0;
      cnt_q <= '0;
      err_q <= 1'b0;
      run_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      run_q <= 1'b1;
    end
  end

  assign y        = y_q;
  assign z        = w_z;
  assign z_count  = cnt_q;
  assign load_err = err_q;

endmodule
`default_nettype wire
